custom_clock_phase_meter: RTL

- Receive-side counterpart of the custom clock generators: measures an incoming divided or derived clock in units of clk_in cycles.
- Reports the high-phase and low-phase durations of each complete period, with a one-cycle valid strobe.
- Used for on-chip self-check of generated clocks and for characterising external clock inputs.
- Input is treated as asynchronous and is synchronised internally.

---
 rtl/custom_clock_phase_meter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/custom_clock_phase_meter.sv
// custom_clock_phase_meter
// Measures the high and low phase lengths of an asynchronous clock (clk_meas)
// in units of clk_in cycles.
// Reports one complete period per valid strobe.
// Counters saturate at all-ones and never wrap.
module custom_clock_phase_meter #(
    parameter int CYCLE_WIDTH = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk_in,
    input  logic                   arst_n,
    input  logic                   enable,
    input  logic                   clk_meas,
    output logic [CYCLE_WIDTH-1:0] high_phase_cycles,
    output logic [CYCLE_WIDTH-1:0] low_phase_cycles,
    output logic                   valid,
    output logic                   overflow,
    output logic                   stalled
);

    localparam logic [CYCLE_WIDTH-1:0] CNT_MAX  = {CYCLE_WIDTH{1'b1}};
    localparam logic [CYCLE_WIDTH-1:0] CNT_ZERO = {CYCLE_WIDTH{1'b0}};
    localparam logic [CYCLE_WIDTH-1:0] CNT_ONE  = {{(CYCLE_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ALIGN     = 2'd1,
        ST_MEAS_HIGH = 2'd2,
        ST_MEAS_LOW  = 2'd3
    } state_t;

    // Saturating increment: holds at all-ones instead of wrapping
    function automatic logic [CYCLE_WIDTH-1:0] sat_inc(input logic [CYCLE_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : (v + CNT_ONE);
    endfunction

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    state_t                 r_state;
    logic [CYCLE_WIDTH-1:0] r_cnt;
    logic [CYCLE_WIDTH-1:0] r_hi_hold;
    logic                   r_hi_sat;
    logic                   r_lo_sat;
    logic [CYCLE_WIDTH-1:0] r_high;
    logic [CYCLE_WIDTH-1:0] r_low;
    logic                   r_valid;
    logic                   r_ovf;
    logic                   r_stalled;

    logic                   w_s;
    logic                   w_rise;
    logic                   w_fall;
    logic [CYCLE_WIDTH-1:0] w_cnt_inc;
    state_t                 w_state_nxt;
    logic [CYCLE_WIDTH-1:0] w_cnt_nxt;
    logic [CYCLE_WIDTH-1:0] w_hi_hold_nxt;
    logic                   w_hi_sat_nxt;
    logic                   w_lo_sat_nxt;
    logic [CYCLE_WIDTH-1:0] w_high_nxt;
    logic [CYCLE_WIDTH-1:0] w_low_nxt;
    logic                   w_valid_nxt;
    logic                   w_ovf_nxt;
    logic                   w_stalled_nxt;

    assign w_s       = r_sync[SYNC_STAGES-1];
    assign w_rise    = w_s & ~r_prev;
    assign w_fall    = ~w_s & r_prev;
    assign w_cnt_inc = sat_inc(r_cnt);

    // Synchroniser chain for clk_meas plus one delay flop for edge detection
    always_ff @(posedge clk_in or negedge arst_n) begin
        if (!arst_n) begin
            r_sync <= {SYNC_STAGES{1'b0}};
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], clk_meas};
            r_prev <= w_s;
        end
    end

    // Next-state and datapath decisions; enable low overrides any edge
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hi_hold_nxt = r_hi_hold;
        w_hi_sat_nxt  = r_hi_sat;
        w_lo_sat_nxt  = r_lo_sat;
        w_high_nxt    = r_high;
        w_low_nxt     = r_low;
        w_valid_nxt   = 1'b0;
        w_ovf_nxt     = r_ovf;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = CNT_ZERO;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cnt_nxt   = CNT_ZERO;
                    w_state_nxt = ST_ALIGN;
                end
                ST_ALIGN: begin
                    // Wait for a rising edge so a partial phase is never measured
                    if (w_rise) begin
                        w_state_nxt  = ST_MEAS_HIGH;
                        w_cnt_nxt    = CNT_ONE;
                        w_hi_sat_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt = CNT_ZERO;
                    end
                end
                ST_MEAS_HIGH: begin
                    if (w_fall) begin
                        w_hi_hold_nxt = r_cnt;
                        w_cnt_nxt     = CNT_ONE;
                        w_lo_sat_nxt  = 1'b0;
                        w_state_nxt   = ST_MEAS_LOW;
                    end else if (w_s) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == CNT_MAX) begin
                            w_hi_sat_nxt = 1'b1;
                        end else begin
                            w_hi_sat_nxt = r_hi_sat;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt;
                    end
                end
                ST_MEAS_LOW: begin
                    // A rise closes the period and immediately opens the next one
                    if (w_rise) begin
                        w_high_nxt   = r_hi_hold;
                        w_low_nxt    = r_cnt;
                        w_ovf_nxt    = r_hi_sat | r_lo_sat;
                        w_valid_nxt  = 1'b1;
                        w_cnt_nxt    = CNT_ONE;
                        w_hi_sat_nxt = 1'b0;
                        w_lo_sat_nxt = 1'b0;
                        w_state_nxt  = ST_MEAS_HIGH;
                    end else if (!w_s) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == CNT_MAX) begin
                            w_lo_sat_nxt = 1'b1;
                        end else begin
                            w_lo_sat_nxt = r_lo_sat;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end
            endcase
        end
        w_stalled_nxt = ((w_state_nxt == ST_MEAS_HIGH) || (w_state_nxt == ST_MEAS_LOW))
                        && (w_cnt_nxt == CNT_MAX);
    end

    // State, counter and registered result outputs
    always_ff @(posedge clk_in or negedge arst_n) begin
        if (!arst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= CNT_ZERO;
            r_hi_hold <= CNT_ZERO;
            r_hi_sat  <= 1'b0;
            r_lo_sat  <= 1'b0;
            r_high    <= CNT_ZERO;
            r_low     <= CNT_ZERO;
            r_valid   <= 1'b0;
            r_ovf     <= 1'b0;
            r_stalled <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hi_hold <= w_hi_hold_nxt;
            r_hi_sat  <= w_hi_sat_nxt;
            r_lo_sat  <= w_lo_sat_nxt;
            r_high    <= w_high_nxt;
            r_low     <= w_low_nxt;
            r_valid   <= w_valid_nxt;
            r_ovf     <= w_ovf_nxt;
            r_stalled <= w_stalled_nxt;
        end
    end

    assign high_phase_cycles = r_high;
    assign low_phase_cycles  = r_low;
    assign valid             = r_valid;
    assign overflow          = r_ovf;
    assign stalled           = r_stalled;

endmodule
